period_meas_sched: RTL and testbench
====================================

// Module: period_meas_sched
// PURPOSE
//  Sequences and shares NCH coarse period-counter channels (PPS edge-to-edge counts) onto one result stream.
//  Arms channels, discards the first partial period, and buffers one sample per channel.
//  Round-robin arbitrates buffered samples onto a valid/ready port read by the host interface.
//  Sits between the per-channel coarse counters and the host readout logic.
// PARAMETERS
//  NCH            2           number of counter channels (>=2)
//  CW             32          counter / result width
//  TIMEOUT_CYCLES 12_000_000  watchdog limit in clk cycles; used only with PMS_TIMEOUT_EN
// PORTS
//  clk      in   1       single clock
//  rst      in   1       asynchronous, active-high reset
//  enable   in   1       global measurement enable
//  chan_en  in   NCH     per-channel enable
//  trigger  in   NCH     1-cycle edge pulse from each counter
//  count_in in   NCH*CW  counter outputs; channel i = [i*CW +: CW]; new value valid the cycle after trigger[i]
//  m_valid  out  1       result valid
//  m_ready  in   1       result accepted
//  m_data   out  CW      captured period count (0 for timeout records)
//  m_chan   out  CHW     source channel, CHW = clog2(NCH)
//  m_flags  out  2       [0] overrun, [1] timeout
//  pending  out  NCH     per-channel slot occupied
// BEHAVIOUR
//  Reset: all outputs 0, all slots/primed/overrun bits 0, FSM IDLE, RR pointer 0.
//  Capture event (ev[i]): trig_d[i] (trigger delayed 1 clk) && enable && chan_en[i].
//  - If primed[i]=0: set primed[i]; discard the sample (partial period).
//  - Else: slot[i] <= count_in[i]; pending[i] <= 1.
//  - If pending[i] was already 1 and is not granted this cycle: overwrite with the newer value and set ovr[i] (sticky until granted).
//  Latency: trigger[i] at T, capture at end of T+1, pending[i]=1 at T+2, m_valid=1 at T+3 (FSM idle, lone requester).
//  FSM IDLE: if any pending, pick the first pending index at or after rr_ptr (wrapping).
//  - Load m_data/m_chan/m_flags, clear pending[g] and ovr[g], rr_ptr <= g+1 mod NCH, go VALID.
//  FSM VALID: m_valid=1; outputs held stable until m_ready.
//  - On handshake with another pending channel: load the next grant in the same cycle and stay VALID (back-to-back, no bubble).
//  - On handshake with nothing pending: go IDLE.
//  Simultaneous grant and capture on the same channel: grant takes the old slot value; the new capture sets pending again with ovr=0.
//  enable=0 or chan_en[i]=0: clears primed[i], pending[i] and ovr[i] for affected channels.
//  - An in-flight VALID record still completes normally; m_valid never drops without a handshake.
//  rst asserted mid-transfer: m_valid drops immediately (async).
// CONFIGURATION
//  Macro PMS_TIMEOUT_EN defined:
//  - Per-channel watchdog counts while enable && chan_en[i]; cleared on ev[i], including the priming event.
//  - When the count reaches TIMEOUT_CYCLES-1: pending[i] <= 1, slot[i] <= 0, timeout flag set, watchdog restarts.
//  - A real capture in the same cycle wins and the timeout is dropped.
//  Macro undefined: no watchdog logic is built; m_flags[1] is tied 0.
// STRUCTURE
//  Package pms_pkg holds:
//  - FSM state enum {IDLE, VALID}
//  - flag bit indices FLG_OVR=0, FLG_TMO=1
//  - clog2 function used to derive CHW
//  Sub-module pms_rr_arbiter: combinational round-robin picker (req[NCH], ptr) -> (gnt_valid, gnt_idx).
// TESTING
//  1 NCH=2, ch0 triggers every 10 clk with count_in=10, m_ready=1 -> first edge discarded; m_data=10, m_chan=0, flags=0, m_valid 3 clk after 2nd trigger.
//  2 m_ready=0, ch0 counts 10 then 11 captured -> single record data=11, flags=2'b01; pending[0]=0 after handshake.
//  3 ch0 and ch1 captures in same cycle, rr_ptr=0, m_ready=1 -> ch0 then ch1 on consecutive cycles, no bubble; rr_ptr ends at 0.
//  4 PMS_TIMEOUT_EN, TIMEOUT_CYCLES=100, ch1 primed then silent -> record chan=1, data=0, flags=2'b10 every 100 clk.
//  5 m_valid=1, m_ready=0, enable dropped -> record holds until m_ready; pending and primed cleared; next edge after re-enable discarded.
//  6 rst pulse while m_valid=1 with both slots pending -> m_valid=0 and pending=0 immediately; resumes after re-priming.

Source files
------------

// File: rtl/pms_pkg.sv
// Shared types and helpers for the period measurement scheduler.
//   pms_state_e : output FSM states (IDLE, VALID)
//   FLG_OVR/TMO : bit positions inside m_flags
//   clog2       : ceiling log2, never below 1 (used to size channel indices)
package pms_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } pms_state_e;

    localparam int FLG_OVR = 0;
    localparam int FLG_TMO = 1;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pms_rr_arbiter.sv
// Combinational round-robin picker.
//   req       in  NCH  requesting channels
//   ptr       in  CHW  highest-priority index this cycle
//   gnt_valid out 1    at least one request present
//   gnt_idx   out CHW  first requesting index at or after ptr (wrapping)
module pms_rr_arbiter
    import pms_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CHW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic           gnt_valid,
    output logic [CHW-1:0] gnt_idx
);

    int idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CHW'(idx);
            end
        end
    end

endmodule

// File: rtl/period_meas_sched.sv
// Period measurement scheduler: arms NCH coarse period counters, drops the
// first (partial) period after arming, buffers one sample per channel and
// round-robins the buffered samples onto a single valid/ready stream.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   enable, chan_en   global / per-channel measurement enable
//   trigger           1-cycle edge pulse per channel
//   count_in          channel i at [i*CW +: CW], valid the cycle after trigger[i]
//   m_valid/m_ready   result handshake
//   m_data            captured count (0 for timeout records)
//   m_chan            source channel
//   m_flags           [FLG_OVR] overrun, [FLG_TMO] timeout
//   pending           per-channel slot occupied
//
// Build option: define PMS_TIMEOUT_EN to add a per-channel watchdog that
// emits a data=0 timeout record after TIMEOUT_CYCLES without an edge.
module period_meas_sched
    import pms_pkg::*;
#(
    parameter  int NCH            = 2,
    parameter  int CW             = 32,
    parameter  int TIMEOUT_CYCLES = 12_000_000,
    localparam int CHW            = clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NCH-1:0]    chan_en,
    input  logic [NCH-1:0]    trigger,
    input  logic [NCH*CW-1:0] count_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     m_data,
    output logic [CHW-1:0]    m_chan,
    output logic [1:0]        m_flags,
    output logic [NCH-1:0]    pending
);

    pms_state_e state_q, state_d;
    logic [CHW-1:0]         rr_q, rr_d;
    logic [NCH-1:0]         trig_d_q, trig_d_d;
    logic [NCH-1:0]         primed_q, primed_d;
    logic [NCH-1:0]         pend_q, pend_d;
    logic [NCH-1:0]         ovr_q, ovr_d;
    logic [NCH-1:0]         tmo_q, tmo_d;
    logic [NCH-1:0][CW-1:0] slot_q, slot_d;
    logic [CW-1:0]          m_data_q, m_data_d;
    logic [CHW-1:0]         m_chan_q, m_chan_d;
    logic [1:0]             m_flags_q, m_flags_d;

    logic [NCH-1:0] act;     // channel currently allowed to measure
    logic [NCH-1:0] ev;      // capture event (count_in valid this cycle)
    logic [NCH-1:0] wd_hit;  // watchdog expiry
    logic           gnt_valid;
    logic [CHW-1:0] gnt_idx;
    logic           do_grant;

    assign act = chan_en & {NCH{enable}};
    assign ev  = trig_d_q & act;

    pms_rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req       (pend_q),
        .ptr       (rr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

`ifdef PMS_TIMEOUT_EN
    localparam int WDW = clog2(TIMEOUT_CYCLES);

    logic [NCH-1:0][WDW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d   = wd_q;
        wd_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wd_hit[i] = act[i] && (wd_q[i] == WDW'(TIMEOUT_CYCLES - 1));
            if (!act[i] || ev[i] || wd_hit[i]) begin
                wd_d[i] = '0;
            end else begin
                wd_d[i] = wd_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_hit = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        trig_d_d  = trigger;
        primed_d  = primed_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
        slot_d    = slot_q;
        m_data_d  = m_data_q;
        m_chan_d  = m_chan_q;
        m_flags_d = m_flags_q;
        do_grant  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    do_grant = 1'b1;
                end
            end
            VALID: begin
                if (m_ready) begin
                    if (gnt_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Grant reads the registered slot, so a same-cycle capture on the
        // granted channel is kept for the next record rather than lost.
        if (do_grant) begin
            state_d            = VALID;
            m_data_d           = slot_q[gnt_idx];
            m_chan_d           = gnt_idx;
            m_flags_d          = '0;
            m_flags_d[FLG_OVR] = ovr_q[gnt_idx];
`ifdef PMS_TIMEOUT_EN
            m_flags_d[FLG_TMO] = tmo_q[gnt_idx];
`endif
            pend_d[gnt_idx]    = 1'b0;
            ovr_d[gnt_idx]     = 1'b0;
            tmo_d[gnt_idx]     = 1'b0;
            if (int'(gnt_idx) == NCH - 1) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx + 1'b1;
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (!act[i]) begin
                primed_d[i] = 1'b0;
                pend_d[i]   = 1'b0;
                ovr_d[i]    = 1'b0;
                tmo_d[i]    = 1'b0;
            end else if (ev[i]) begin
                if (!primed_q[i]) begin
                    primed_d[i] = 1'b1;
                end else begin
                    slot_d[i] = count_in[i*CW +: CW];
                    pend_d[i] = 1'b1;
                    tmo_d[i]  = 1'b0;
                    ovr_d[i]  = ovr_d[i] |
                                (pend_q[i] && !(do_grant && int'(gnt_idx) == i));
                end
            end else if (wd_hit[i]) begin
                slot_d[i] = '0;
                pend_d[i] = 1'b1;
                tmo_d[i]  = 1'b1;
                ovr_d[i]  = ovr_d[i] |
                            (pend_q[i] && !(do_grant && int'(gnt_idx) == i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            trig_d_q  <= '0;
            primed_q  <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
            tmo_q     <= '0;
            slot_q    <= '0;
            m_data_q  <= '0;
            m_chan_q  <= '0;
            m_flags_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            trig_d_q  <= trig_d_d;
            primed_q  <= primed_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            slot_q    <= slot_d;
            m_data_q  <= m_data_d;
            m_chan_q  <= m_chan_d;
            m_flags_q <= m_flags_d;
        end
    end

    assign m_valid = (state_q == VALID);
    assign m_data  = m_data_q;
    assign m_chan  = m_chan_q;
    assign m_flags = m_flags_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_period_meas_sched.sv
module tb_period_meas_sched;

    localparam int NCH = 2;
    localparam int CW  = 32;

    typedef struct packed {
        logic [CW-1:0] data;
        logic [0:0]    chan;
        logic [1:0]    flags;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    trigger;
    logic [NCH*CW-1:0] count_in;
    logic              m_valid;
    logic              m_ready;
    logic [CW-1:0]     m_data;
    logic [0:0]        m_chan;
    logic [1:0]        m_flags;
    logic [NCH-1:0]    pending;

    rec_t exp_q[$];
    int   hs_cyc[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   cyc      = 0;

    period_meas_sched #(
        .NCH            (NCH),
        .CW             (CW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .chan_en  (chan_en),
        .trigger  (trigger),
        .count_in (count_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_chan   (m_chan),
        .m_flags  (m_flags),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted record is popped against the expectation
    // queued when its stimulus was driven.
    always @(negedge clk) begin
        rec_t e;
        if (!rst && m_valid && m_ready) begin
            hs_cyc.push_back(cyc);
            tot_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL record_unexpected: got data=%0d chan=%0d flags=%b, required no record",
                         m_data, m_chan, m_flags);
            end else begin
                e = exp_q.pop_front();
                if ({m_data, m_chan, m_flags} !== e) begin
                    $display("FAIL record: got data=%0d chan=%0d flags=%b, required data=%0d chan=%0d flags=%b",
                             m_data, m_chan, m_flags, e.data, e.chan, e.flags);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        @(posedge clk);
        #1;
        count_in = {c1, c0};
        trigger  = m;
        @(posedge clk);
        #1;
        trigger  = '0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        ok = (exp_q.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; chan_en = '0; trigger = '0; count_in = '0; m_ready = 1'b0;
        idle(3);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b000) $display("FAIL reset_valid_pending: got %b, required 000", {m_valid, pending});
        else pass_cnt++;
        tot_cnt++;
        if ({m_data, m_chan, m_flags} !== '0) $display("FAIL reset_data: got data=%0d chan=%0d flags=%b, required 0", m_data, m_chan, m_flags);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_first_period();
        bit ok;
        enable = 1'b1; chan_en = 2'b01; m_ready = 1'b1;
        pulse(2'b01, 10, 0);
        idle(3);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b000) $display("FAIL first_discard: got valid/pending=%b, required 000", {m_valid, pending});
        else pass_cnt++;
        idle(5);
        exp_q.push_back(rec_t'{32'd10, 1'b0, 2'b00});
        pulse(2'b01, 10, 0);
        @(posedge clk); #1;
        tot_cnt++;
        if ({m_valid, pending} !== 3'b001) $display("FAIL latency_t2: got valid/pending=%b, required 001", {m_valid, pending});
        else pass_cnt++;
        @(posedge clk); #1;
        tot_cnt++;
        if (m_valid !== 1'b1) $display("FAIL latency_t3: got m_valid=%b, required 1", m_valid);
        else pass_cnt++;
        drain(20, ok);
        tot_cnt++;
        if (!ok) $display("FAIL drain_first: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        bit ok;
        chan_en = 2'b11; m_ready = 1'b0;
        pulse(2'b10, 0, 7);
        idle(2);
        exp_q.push_back(rec_t'{32'd77, 1'b1, 2'b00});
        pulse(2'b10, 0, 77);
        idle(3);
        pulse(2'b01, 10, 0);
        pulse(2'b01, 11, 0);
        idle(2);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b101) $display("FAIL overrun_pending: got valid/pending=%b, required 101", {m_valid, pending});
        else pass_cnt++;
        exp_q.push_back(rec_t'{32'd11, 1'b0, 2'b01});
        m_ready = 1'b1;
        drain(20, ok);
        tot_cnt++;
        if (!ok) $display("FAIL drain_overrun: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
        idle(1);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b000) $display("FAIL overrun_cleared: got valid/pending=%b, required 000", {m_valid, pending});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        enable = 1'b1; chan_en = 2'b11; m_ready = 1'b1;
        pulse(2'b11, 0, 0);
        idle(2);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(rec_t'{32'(5 + 2*r), 1'b0, 2'b00});
            exp_q.push_back(rec_t'{32'(6 + 2*r), 1'b1, 2'b00});
            pulse(2'b11, 32'(5 + 2*r), 32'(6 + 2*r));
            drain(20, ok);
            tot_cnt++;
            if (!ok) $display("FAIL drain_b2b: got %0d outstanding, required 0", exp_q.size());
            else pass_cnt++;
            tot_cnt++;
            if (hs_cyc.size() < 2 || hs_cyc[$] - hs_cyc[$-1] != 1)
                $display("FAIL b2b_gap: got %0d cycles between records, required 1",
                         (hs_cyc.size() < 2) ? -1 : hs_cyc[$] - hs_cyc[$-1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_disable();
        bit ok;
        m_ready = 1'b0;
        exp_q.push_back(rec_t'{32'd55, 1'b0, 2'b00});
        pulse(2'b01, 55, 0);
        idle(3);
        pulse(2'b10, 0, 66);
        idle(2);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b110) $display("FAIL dis_before: got valid/pending=%b, required 110", {m_valid, pending});
        else pass_cnt++;
        enable = 1'b0;
        idle(1);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b100) $display("FAIL dis_cleared: got valid/pending=%b, required 100", {m_valid, pending});
        else pass_cnt++;
        idle(5);
        tot_cnt++;
        if (m_valid !== 1'b1 || m_data !== 32'd55) $display("FAIL dis_hold: got valid=%b data=%0d, required 1/55", m_valid, m_data);
        else pass_cnt++;
        m_ready = 1'b1;
        drain(10, ok);
        idle(1);
        tot_cnt++;
        if (!ok || m_valid !== 1'b0) $display("FAIL dis_release: got valid=%b outstanding=%0d, required 0/0", m_valid, exp_q.size());
        else pass_cnt++;
        enable = 1'b1;
        pulse(2'b01, 99, 0);
        idle(4);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b000) $display("FAIL dis_rearm_discard: got valid/pending=%b, required 000", {m_valid, pending});
        else pass_cnt++;
        exp_q.push_back(rec_t'{32'd100, 1'b0, 2'b00});
        pulse(2'b01, 100, 0);
        drain(20, ok);
        tot_cnt++;
        if (!ok) $display("FAIL drain_rearm: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        m_ready = 1'b0;
        pulse(2'b11, 1, 2);
        idle(3);
        pulse(2'b11, 3, 4);
        idle(2);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b111) $display("FAIL mid_before: got valid/pending=%b, required 111", {m_valid, pending});
        else pass_cnt++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        tot_cnt++;
        if ({m_valid, pending, m_data} !== '0) $display("FAIL mid_async: got valid=%b pending=%b data=%0d, required 0", m_valid, pending, m_data);
        else pass_cnt++;
        idle(2);
        rst = 1'b0;
        m_ready = 1'b1;
        pulse(2'b01, 8, 0);
        idle(4);
        tot_cnt++;
        if ({m_valid, pending} !== 3'b000) $display("FAIL mid_reprime: got valid/pending=%b, required 000", {m_valid, pending});
        else pass_cnt++;
        exp_q.push_back(rec_t'{32'd9, 1'b0, 2'b00});
        pulse(2'b01, 9, 0);
        drain(20, ok);
        tot_cnt++;
        if (!ok) $display("FAIL drain_resume: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
    endtask

`ifdef PMS_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        enable = 1'b1; chan_en = 2'b10; m_ready = 1'b1;
        pulse(2'b10, 0, 0);
        exp_q.push_back(rec_t'{32'd0, 1'b1, 2'b10});
        exp_q.push_back(rec_t'{32'd0, 1'b1, 2'b10});
        drain(400, ok);
        tot_cnt++;
        if (!ok) $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
        tot_cnt++;
        if (hs_cyc.size() < 2 || hs_cyc[$] - hs_cyc[$-1] != 100)
            $display("FAIL timeout_period: got %0d, required 100",
                     (hs_cyc.size() < 2) ? -1 : hs_cyc[$] - hs_cyc[$-1]);
        else pass_cnt++;
        chan_en = 2'b00;
        idle(2);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_period();
        test_overrun();
        test_back_to_back();
        test_disable();
        test_reset_mid();
`ifdef PMS_TIMEOUT_EN
        test_timeout();
`endif
        idle(5);
        tot_cnt++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
